// File: rtl/mirfak_pkg.sv
// Shared definitions for the mirfak core data-side load/store path:
// access size encodings, LSU state encoding and the default bus timeout.
package mirfak_pkg;

    // Access size encodings carried on lsu_size_i (2'b11 is reserved).
    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    // Cycles a bus access may stay open without ack/err before it is aborted.
    localparam int unsigned LSU_TIMEOUT_DEFAULT = 32'd255;

    // Load/store unit control state.
    typedef enum logic [0:0] {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/dwbm_lsu_align.sv
// Combinational data aligner for the load/store unit: alignment check,
// byte-lane enables, store data replication and load data extraction with
// sign/zero extension. One instance serves both the request and response path.
module dwbm_lsu_align
    import mirfak_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic        misaligned,
    output logic [3:0]  sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] rdata
);

    logic [31:0] shifted_s;

    // Request side: alignment check, lane enables and lane-replicated store data.
    always_comb begin
        misaligned = 1'b1;
        sel        = 4'b0000;
        bus_wdata  = 32'h0000_0000;
        case (size)
            LSU_BYTE: begin
                misaligned = 1'b0;
                sel        = 4'b0001 << addr_lo;
                bus_wdata  = {4{wdata[7:0]}};
            end
            LSU_HALF: begin
                misaligned = addr_lo[0];
                sel        = 4'b0011 << addr_lo;
                bus_wdata  = {2{wdata[15:0]}};
            end
            LSU_WORD: begin
                misaligned = (addr_lo != 2'b00);
                sel        = 4'b1111;
                bus_wdata  = wdata;
            end
            default: begin
                misaligned = 1'b1;
                sel        = 4'b0000;
                bus_wdata  = 32'h0000_0000;
            end
        endcase
    end

    // Response side: bring the addressed lanes down to bit 0 and extend.
    always_comb begin
        shifted_s = bus_rdata >> {addr_lo, 3'b000};
        rdata     = 32'h0000_0000;
        case (size)
            LSU_BYTE: begin
                if (is_unsigned) begin
                    rdata = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            LSU_HALF: begin
                if (is_unsigned) begin
                    rdata = {16'h0000, shifted_s[15:0]};
                end else begin
                    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            LSU_WORD: begin
                rdata = shifted_s;
            end
            default: begin
                rdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dwbm_lsu.sv
// Load/store unit: Wishbone classic master on the core data port. Takes one
// request at a time, rejects misaligned accesses without touching the bus,
// runs one bus cycle per aligned access and reports completion, misalignment,
// bus error or timeout with a single-cycle valid pulse.
module dwbm_lsu
    import mirfak_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    output logic        lsu_ready_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_buserr_o,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    output logic        dwbm_we_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;
    logic [1:0]       addr_lo_r;
    logic [1:0]       size_r;
    logic             unsigned_r;
    logic [3:0]       sel_r;
    logic [31:0]      dat_r;
    logic             we_r;
    logic             cyc_r;
    logic             valid_r;
    logic             misaligned_r;
    logic             buserr_r;
    logic [31:0]      rdata_r;

    logic [1:0]       alg_addr_s;
    logic [1:0]       alg_size_s;
    logic             alg_unsigned_s;
    logic             misaligned_s;
    logic [3:0]       sel_s;
    logic [31:0]      wdat_s;
    logic [31:0]      rdata_fmt_s;

    // The aligner looks at the incoming request while idle and at the latched
    // access while a bus cycle is open, so one instance covers both paths.
    always_comb begin
        if (state_r == LSU_IDLE) begin
            alg_addr_s     = lsu_addr_i[1:0];
            alg_size_s     = lsu_size_i;
            alg_unsigned_s = lsu_unsigned_i;
        end else begin
            alg_addr_s     = addr_lo_r;
            alg_size_s     = size_r;
            alg_unsigned_s = unsigned_r;
        end
    end

    dwbm_lsu_align u_align (
        .addr_lo     (alg_addr_s),
        .size        (alg_size_s),
        .is_unsigned (alg_unsigned_s),
        .wdata       (lsu_wdata_i),
        .bus_rdata   (dwbm_dat_i),
        .misaligned  (misaligned_s),
        .sel         (sel_s),
        .bus_wdata   (wdat_s),
        .rdata       (rdata_fmt_s)
    );

    // Control FSM, timeout counter and all registered bus/pipeline outputs.
    // Status outputs default to zero every cycle so they only pulse with valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= LSU_IDLE;
            cnt_r        <= '0;
            addr_r       <= 32'h0000_0000;
            addr_lo_r    <= 2'b00;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            sel_r        <= 4'b0000;
            dat_r        <= 32'h0000_0000;
            we_r         <= 1'b0;
            cyc_r        <= 1'b0;
            valid_r      <= 1'b0;
            misaligned_r <= 1'b0;
            buserr_r     <= 1'b0;
            rdata_r      <= 32'h0000_0000;
        end else begin
            valid_r      <= 1'b0;
            misaligned_r <= 1'b0;
            buserr_r     <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            case (state_r)
                LSU_IDLE: begin
                    // Terminations arriving here belong to no access and are ignored.
                    if (lsu_req_i) begin
                        if (misaligned_s) begin
                            valid_r      <= 1'b1;
                            misaligned_r <= 1'b1;
                        end else begin
                            state_r    <= LSU_BUSY;
                            cnt_r      <= '0;
                            addr_r     <= {lsu_addr_i[31:2], 2'b00};
                            addr_lo_r  <= lsu_addr_i[1:0];
                            size_r     <= lsu_size_i;
                            unsigned_r <= lsu_unsigned_i;
                            sel_r      <= sel_s;
                            dat_r      <= wdat_s;
                            we_r       <= lsu_we_i;
                            cyc_r      <= 1'b1;
                        end
                    end
                end
                LSU_BUSY: begin
                    // Error wins over a simultaneous ack; timeout is the last resort.
                    if (dwbm_err_i) begin
                        state_r  <= LSU_IDLE;
                        cyc_r    <= 1'b0;
                        valid_r  <= 1'b1;
                        buserr_r <= 1'b1;
                    end else if (dwbm_ack_i) begin
                        state_r <= LSU_IDLE;
                        cyc_r   <= 1'b0;
                        valid_r <= 1'b1;
                        rdata_r <= we_r ? 32'h0000_0000 : rdata_fmt_s;
                    end else if (cnt_r == CNT_W'(TIMEOUT)) begin
                        state_r  <= LSU_IDLE;
                        cyc_r    <= 1'b0;
                        valid_r  <= 1'b1;
                        buserr_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= LSU_IDLE;
                    cyc_r   <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_ready_o      = (state_r == LSU_IDLE);
    assign lsu_valid_o      = valid_r;
    assign lsu_rdata_o      = rdata_r;
    assign lsu_misaligned_o = misaligned_r;
    assign lsu_buserr_o     = buserr_r;
    assign dwbm_addr_o      = addr_r;
    assign dwbm_dat_o       = dat_r;
    assign dwbm_sel_o       = sel_r;
    assign dwbm_cyc_o       = cyc_r;
    assign dwbm_stb_o       = cyc_r;
    assign dwbm_we_o        = we_r;

endmodule

// File: doc/dwbm_lsu.md
# dwbm_lsu

Load/store unit acting as Wishbone classic bus master on the core's data port (dwbm_*), the initiator counterpart of the data-side memory responder. Accepts one load/store request at a time from the execute stage and checks alignment. Drives byte lanes, formats store data and sign/zero-extends load data. Reports completion, misalignment, bus error or timeout back to the pipeline.

## Interface
- TIMEOUT, 255: cycles of cyc_o without ack_i/err_i before the master aborts the access with an error; must be ≥ 1.
- clk_i  in  1  core clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- lsu_req_i  in  1  request strobe; taken only when lsu_ready_o = 1.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- lsu_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- lsu_ready_o  out  1  unit idle and able to accept a request.
- lsu_valid_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  32  formatted load data; valid with lsu_valid_o on loads.
- lsu_misaligned_o  out  1  with lsu_valid_o: access rejected for alignment; no bus cycle was issued.
- lsu_buserr_o  out  1  with lsu_valid_o: err_i was received or the access timed out.
- dwbm_addr_o  out  32  word-aligned address {addr[31:2], 2'b00}.
- dwbm_dat_o  out  32  lane-replicated store data.
- dwbm_sel_o  out  4  byte lane enables.
- dwbm_cyc_o, dwbm_stb_o  out  1  cycle and strobe; always equal.
- dwbm_we_o  out  1  write enable.
- dwbm_dat_i  in  32  read data.
- dwbm_ack_i, dwbm_err_i  in  1  termination.

## Operation
- **FSM states:** IDLE and BUSY. lsu_ready_o = (state == IDLE), combinational.
- **IDLE, request present:**
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11): stay in IDLE; next cycle lsu_valid_o = 1 and lsu_misaligned_o = 1.
  - Aligned request: register addr/sel/dat/we, go to BUSY, clear the timeout counter.
- **BUSY:**
  - cyc_o/stb_o = 1; all dwbm_* outputs held stable.
  - err_i = 1: go to IDLE; next cycle valid = 1 and buserr = 1. err_i has priority over a simultaneous ack_i.
  - ack_i = 1: capture the formatted dat_i, go to IDLE; next cycle valid = 1.
  - Counter reaches TIMEOUT: go to IDLE; next cycle valid = 1 and buserr = 1.
- **Byte lanes (sel_o):**
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- **Store data (dat_o):**
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **Load data:** shift dat_i right by 8·addr[1:0], take the low 8/16/32 bits, then extend per lsu_unsigned_i.
- **Spurious termination:** ack_i or err_i seen in IDLE is ignored.
- **Reset:** asynchronous reset mid-access drops cyc_o/stb_o immediately and returns to IDLE; no lsu_valid_o is produced for the aborted access.

## Timing
- **Reset values:** state IDLE; cyc_o, stb_o, we_o = 0; addr_o, dat_o = 0; sel_o = 0; lsu_valid_o, lsu_misaligned_o, lsu_buserr_o = 0; lsu_rdata_o = 0; counter 0.
- All dwbm_* and lsu_* outputs are registered, except lsu_ready_o.
- **Zero-wait slave** (ack_i combinational on stb): request accepted at cycle N, cyc/stb high in N+1, valid in N+2. Latency is 2 cycles.
- **Throughput:** ready is high in N+2, so a back-to-back request is accepted in the valid cycle; one access per 2 cycles.
- **Wait states:** each wait state adds one cycle.
- **Timeout:** valid arrives TIMEOUT+1 cycles after cyc_o rises.
- **Misaligned request:** valid one cycle after acceptance.
- lsu_misaligned_o, lsu_buserr_o and lsu_rdata_o are meaningful only while lsu_valid_o = 1. They are zero otherwise.

## Structure
- **Shared package mirfak_pkg:**
  - size encodings LSU_BYTE/LSU_HALF/LSU_WORD
  - FSM state encoding
  - default TIMEOUT constant
- **Sub-module dwbm_lsu_align (combinational):** alignment check, sel generation, store replication, load extraction/extension. Reused by both the request and the response path.
- Top level holds the FSM, the timeout counter and the output registers.

## Test plan
- **Word store/load:** store 0xDEADBEEF @0x100 then load word @0x100 against the zero-wait RAM model -> sel 1111; rdata 0xDEADBEEF; valid 2 cycles after each accept.
- **Byte lanes:** store byte 0x80 @0x103, then load signed byte @0x103 and unsigned byte @0x103 -> store has sel 1000 and dat 0x80808080; loads return 0xFFFFFF80 and 0x00000080.
- **Half lanes:** load signed half @0x102 when the word is 0x8001xxxx -> sel 1100; rdata 0xFFFF8001.
- **Misalignment:** half @0x101, word @0x102, size 11 -> misaligned pulse 1 cycle after accept; cyc_o never asserted.
- **Errors:** slave with 3 wait states then err_i together with ack_i -> buserr = 1. Slave never acks, TIMEOUT = 4 -> buserr pulse exactly 5 cycles after cyc_o rises; cyc_o low afterwards.
- **Reset and pipelining:** rstn_i low during BUSY -> cyc/stb low asynchronously and no valid. Back-to-back requests -> accepted in each valid cycle.
